// File: rtl/lsu_mem_ctrl_if.sv
// CPU request/response and data-memory port bundle for lsu_mem_ctrl.
// slave = controller view, master = CPU/memory side (testbench) view.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              w_req_valid;
  logic              w_req_ready;
  logic [2:0]        w_req_op;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic              w_rsp_err;
  logic              w_mem_en;
  logic              w_mem_write_op;
  logic              w_mem_byte_op;
  logic [ADDR_W-1:0] w_mem_addr_32;
  logic [DATA_W-1:0] w_mem_data_in_32;
  logic [DATA_W-1:0] w_mem_data_out_32;
  logic [7:0]        w_mem_data_out_8;

  modport slave (
    input  w_req_valid, w_req_op, w_req_addr, w_req_wdata,
           w_mem_data_out_32, w_mem_data_out_8,
    output w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err,
           w_mem_en, w_mem_write_op, w_mem_byte_op, w_mem_addr_32, w_mem_data_in_32
  );

  modport master (
    output w_req_valid, w_req_op, w_req_addr, w_req_wdata,
           w_mem_data_out_32, w_mem_data_out_8,
    input  w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err,
           w_mem_en, w_mem_write_op, w_mem_byte_op, w_mem_addr_32, w_mem_data_in_32
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a big-endian byte-addressed data memory; halfwords use two byte cycles.
// Optional misalignment trap: define LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic         clock,
  input logic         reset_n,
  lsu_mem_ctrl_if.slave bus
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        acc_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] ld_data;
  logic              accept, misalign;
  logic              op_word, op_half, op_store, req_word, req_half;
  logic [7:0]        b;

  assign b        = bus.w_mem_data_out_8;
  assign accept   = (state == IDLE) && bus.w_req_valid;
  assign op_word  = (op_q == OP_LW) || (op_q == OP_SW);
  assign op_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
  assign op_store = (op_q == OP_SW) || (op_q == OP_SB) || (op_q == OP_SH);
  assign req_word = (bus.w_req_op == OP_LW) || (bus.w_req_op == OP_SW);
  assign req_half = (bus.w_req_op == OP_LH) || (bus.w_req_op == OP_LHU) || (bus.w_req_op == OP_SH);

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = (req_word && (bus.w_req_addr[1:0] != 2'b00)) || (req_half && bus.w_req_addr[0]);
`else
  assign misalign = 1'b0 & req_word & req_half;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = misalign ? RESP : ACC0;
      ACC0: state_nxt = op_half ? ACC1 : RESP;
      ACC1: state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load result as it will look at the end of the final access cycle;
  // acc_q holds the high (lower-address) byte of a halfword.
  always_comb begin
    ld_data = '0;
    case (op_q)
      OP_LW:  ld_data = bus.w_mem_data_out_32;
      OP_LB:  ld_data = {{24{b[7]}}, b};
      OP_LBU: ld_data = {24'b0, b};
      OP_LH:  ld_data = {{16{acc_q[7]}}, acc_q, b};
      OP_LHU: ld_data = {16'b0, acc_q, b};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.w_req_op;
        addr_q  <= bus.w_req_addr;
        wdata_q <= bus.w_req_wdata;
      end
      if (state == ACC0) acc_q <= b;
      // Response registers change only on entry to RESP; a direct jump from IDLE is a trap.
      if (state_nxt == RESP && state != RESP) begin
        rsp_rdata_q <= (state == IDLE) ? '0 : ld_data;
        rsp_err_q   <= (state == IDLE);
      end
    end
  end

  always_comb begin
    bus.w_req_ready      = (state == IDLE);
    bus.w_rsp_valid      = (state == RESP);
    bus.w_rsp_rdata      = rsp_rdata_q;
    bus.w_rsp_err        = rsp_err_q;
    bus.w_mem_en         = 1'b0;
    bus.w_mem_write_op   = 1'b0;
    bus.w_mem_byte_op    = 1'b0;
    bus.w_mem_addr_32    = '0;
    bus.w_mem_data_in_32 = '0;
    case (state)
      ACC0: begin
        bus.w_mem_en       = 1'b1;
        bus.w_mem_write_op = op_store;
        bus.w_mem_byte_op  = !op_word;
        bus.w_mem_addr_32  = addr_q;
        case (op_q)
          OP_SW:   bus.w_mem_data_in_32 = wdata_q;
          OP_SB:   bus.w_mem_data_in_32 = {24'b0, wdata_q[7:0]};
          OP_SH:   bus.w_mem_data_in_32 = {24'b0, wdata_q[15:8]};
          default: bus.w_mem_data_in_32 = '0;
        endcase
      end
      ACC1: begin
        bus.w_mem_en         = 1'b1;
        bus.w_mem_write_op   = (op_q == OP_SH);
        bus.w_mem_byte_op    = 1'b1;
        bus.w_mem_addr_32    = addr_q + ADDR_W'(1);
        bus.w_mem_data_in_32 = (op_q == OP_SH) ? {24'b0, wdata_q[7:0]} : '0;
      end
      default: ;
    endcase
    // Reset kills any in-flight memory cycle immediately.
    if (!reset_n) begin
      bus.w_mem_en       = 1'b0;
      bus.w_mem_write_op = 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed scoreboard bench for lsu_mem_ctrl with a 256-byte big-endian memory model.
module tb_lsu_mem_ctrl;
  localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  int          cyc = 0, wr_cnt = 0, en_cnt = 0, rsp_cnt = 0;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] wr_addr_log[$], wr_data_log[$];
  logic        wr_byte_log[$];
  exp_t        sbq[$];
  int          accq[$];
  logic        prev_rsp = 1'b0;

  assign ma = bus.w_mem_addr_32[7:0];
  assign bus.w_mem_data_out_8  = mem[ma];
  assign bus.w_mem_data_out_32 = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    if (bus.w_mem_en) en_cnt++;
    if (bus.w_mem_en && bus.w_mem_write_op) begin
      wr_cnt++;
      wr_addr_log.push_back(bus.w_mem_addr_32);
      wr_data_log.push_back(bus.w_mem_data_in_32);
      wr_byte_log.push_back(bus.w_mem_byte_op);
      if (bus.w_mem_byte_op) mem[ma] <= bus.w_mem_data_in_32[7:0];
      else begin
        mem[ma]        <= bus.w_mem_data_in_32[31:24];
        mem[ma + 8'd1] <= bus.w_mem_data_in_32[23:16];
        mem[ma + 8'd2] <= bus.w_mem_data_in_32[15:8];
        mem[ma + 8'd3] <= bus.w_mem_data_in_32[7:0];
      end
    end
    if (reset_n && bus.w_req_valid && bus.w_req_ready) accq.push_back(cyc + 1);
    cyc++;
  end

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.w_rsp_valid) begin
        rsp_cnt++;
        chk("rsp_single_pulse", {31'b0, prev_rsp}, 32'd0);
        chk("ready_low_in_resp", {31'b0, bus.w_req_ready}, 32'd0);
        if (sbq.size() == 0 || accq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: got rdata %h with no pending request", bus.w_rsp_rdata);
        end else begin
          exp_t e;
          int   a;
          e = sbq.pop_front();
          a = accq.pop_front();
          chk("rsp_rdata", bus.w_rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, bus.w_rsp_err}, {31'b0, e.err});
          chk("rsp_latency", cyc - a + 1, e.lat);
        end
      end
      if (!bus.w_mem_en) begin
        chk("idle_mem_addr", bus.w_mem_addr_32, 32'd0);
        chk("idle_mem_din", bus.w_mem_data_in_32, 32'd0);
        chk("idle_mem_ctl", {30'b0, bus.w_mem_write_op, bus.w_mem_byte_op}, 32'd0);
      end
    end
    prev_rsp = reset_n && bus.w_rsp_valid;
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat, input bit keep);
    exp_t e;
    bit   ok;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sbq.push_back(e);
    @(negedge clock);
    bus.w_req_valid = 1'b1;
    bus.w_req_op    = op;
    bus.w_req_addr  = addr;
    bus.w_req_wdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.w_req_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: ready stayed 0, want 1 within 50 cycles");
      void'(sbq.pop_back());
      bus.w_req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    if (!keep) bus.w_req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (sbq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding, want 0", sbq.size());
      sbq.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int w0, e0, r0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    bus.w_req_valid = 1'b0;
    bus.w_req_op    = 3'd0;
    bus.w_req_addr  = '0;
    bus.w_req_wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_ready", {31'b0, bus.w_req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, bus.w_rsp_valid}, 32'd0);
    chk("reset_rdata", bus.w_rsp_rdata, 32'd0);
    chk("reset_err", {31'b0, bus.w_rsp_err}, 32'd0);

    // Word store / load
    w0 = wr_cnt;
    issue(OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
    drain();
    chk("sw_write_cycles", wr_cnt - w0, 32'd1);
    chk("sw_byte_op", {31'b0, wr_byte_log[$]}, 32'd0);
    chk("sw_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);
    issue(OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
    drain();

    // Byte store / signed and unsigned loads
    w0 = wr_cnt;
    issue(OP_SB, 32'h21, 32'h12345680, 32'h0, 1'b0, 2, 1'b0);
    drain();
    chk("sb_write_cycles", wr_cnt - w0, 32'd1);
    chk("sb_byte_op", {31'b0, wr_byte_log[$]}, 32'd1);
    chk("sb_mem", {24'b0, mem[8'h21]}, 32'h80);
    chk("sb_neighbour", {24'b0, mem[8'h22]}, 32'h22);
    issue(OP_LB, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0);
    issue(OP_LBU, 32'h21, 32'h0, 32'h00000080, 1'b0, 2, 1'b0);
    drain();

    // Halfword store as two byte cycles, high byte first
    w0 = wr_cnt;
    issue(OP_SH, 32'h30, 32'h0000F00D, 32'h0, 1'b0, 3, 1'b0);
    drain();
    chk("sh_write_cycles", wr_cnt - w0, 32'd2);
    if (wr_addr_log.size() >= 2) begin
      chk("sh_wr0_addr", wr_addr_log[wr_addr_log.size()-2], 32'h30);
      chk("sh_wr0_data", wr_data_log[wr_data_log.size()-2], 32'hF0);
      chk("sh_wr1_addr", wr_addr_log[wr_addr_log.size()-1], 32'h31);
      chk("sh_wr1_data", wr_data_log[wr_data_log.size()-1], 32'h0D);
    end
    issue(OP_LH, 32'h30, 32'h0, 32'hFFFFF00D, 1'b0, 3, 1'b0);
    issue(OP_LHU, 32'h30, 32'h0, 32'h0000F00D, 1'b0, 3, 1'b0);
    drain();

    // Back-to-back with valid held high
    r0 = rsp_cnt;
    issue(OP_LB, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
    issue(OP_LHU, 32'h30, 32'h0, 32'h0000F00D, 1'b0, 3, 1'b1);
    issue(OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
    drain();
    chk("b2b_rsp_count", rsp_cnt - r0, 32'd3);

    // Reset during ACC0 of a store
    issue(OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
    drain();
    w0 = wr_cnt;
    @(negedge clock);
    bus.w_req_valid = 1'b1;
    bus.w_req_op    = OP_SW;
    bus.w_req_addr  = 32'h40;
    bus.w_req_wdata = 32'h11223344;
    @(posedge clock);
    #1 bus.w_req_valid = 1'b0;
    @(negedge clock);
    chk("rst_acc0_mem_en", {31'b0, bus.w_mem_en}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    accq.delete();
    chk("rst_ready", {31'b0, bus.w_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.w_rsp_valid}, 32'd0);
    chk("rst_rdata", bus.w_rsp_rdata, 32'd0);
    chk("rst_no_write", wr_cnt - w0, 32'd0);
    chk("rst_mem40", {24'b0, mem[8'h40]}, 32'h40);
    r0 = rsp_cnt;
    repeat (4) @(negedge clock);
    chk("rst_no_rsp", rsp_cnt - r0, 32'd0);

    // Unaligned word load
    e0 = en_cnt;
`ifdef LSU_ALIGN_CHECK_EN
    issue(OP_LW, 32'h42, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    drain();
    chk("misalign_no_mem", en_cnt - e0, 32'd0);
`else
    issue(OP_LW, 32'h42, 32'h0, 32'h42434445, 1'b0, 2, 1'b0);
    drain();
    chk("unaligned_mem_cycles", en_cnt - e0, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog");
  end
endmodule
